aq_djpeg_hm_bitpack: RTL
========================

Name: aq_djpeg_hm_bitpack

Overview:
Bitstream writer for the JPEG entropy-coded segment, on the encoder side of the Huffman decoder. It consumes variable-width code words: the Huffman code concatenated with the amplitude bits, up to 27 bits each. It packs them MSB-first into bytes, inserts 0x00 after every emitted 0xFF, and pads the final byte with 1s on flush. It feeds the byte output path; its stream is what the Huffman decoder later consumes.

Parameters:
MAX_WIDTH, 27, maximum code-word width in bits accepted per transfer.
BUF_WIDTH, 64, bit accumulator size; must be at least MAX_WIDTH+32.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
ProcessInit  input  1  synchronous clear of accumulator and state
DataInEnable  input  1  code word valid
DataInReady  output  1  block can accept a code word this cycle
CodeIn  input  27  code word; bits [CodeWidth-1:0] valid, bit CodeWidth-1 sent first
CodeWidth  input  5  number of valid bits, 0..27
FlushIn  input  1  pulse: terminate segment
FlushDone  output  1  one-cycle pulse when flush (and EOI if enabled) complete
DataOutEnable  output  1  byte valid
DataOutRead  input  1  consumer takes byte
DataOut  output  8  output byte

Behaviour:
- Reset (rst high, async): DataOutEnable=0, DataOut=0x00, FlushDone=0, DataInReady=0; accumulator and bit count cleared; state RUN. ProcessInit has the same effect synchronously. ProcessInit has priority over all other inputs.
- Input transfer occurs on DataInEnable && DataInReady.
- DataInReady=1 only in state RUN with BitCount <= BUF_WIDTH-MAX_WIDTH (37 at default). It is registered, so it may lag by one cycle; the threshold already covers this margin.
- CodeWidth=0: no-op transfer, still handshaken.
- CodeWidth 28..31: treated as 27.
- Accumulator: appended bits go immediately below the existing valid bits. BitCount += width.
- Byte output: when BitCount >= 8 and the output register is free or being read this cycle, load the top 8 bits into DataOut, set DataOutEnable=1, and set BitCount -= 8.
  - At most one byte is emitted per cycle.
  - DataOut and DataOutEnable are held stable until DataOutRead.
  - DataOutRead with DataOutEnable=0 is ignored.
- Stuffing: when a 0xFF byte is accepted by the consumer, the state goes to STUFF. STUFF emits 0x00 as the next byte before any further accumulator byte, then returns to RUN.
  - Input acceptance continues during STUFF if the threshold allows.
- States:
  - RUN: normal operation.
  - STUFF: single 0x00 insertion.
  - FLUSH: drain the accumulator. If BitCount mod 8 != 0, pad with 1s to the byte boundary, then emit remaining bytes. Stuffing still applies, since padding can create 0xFF.
  - EOI_FF and EOI_D9: present only with the optional feature.
  - DONE: FlushDone=1 for one cycle, then RUN with the accumulator empty.
- FlushIn is sampled in RUN only; it is ignored elsewhere. DataInReady=0 from FLUSH through DONE.
- FlushIn coincident with an accepted code word: the word is appended first and included in the flush.
- Flush with BitCount=0 and no pending stuff: goes straight to DONE (or to EOI) with no padding byte.
- Latency: a code word completing a byte shows DataOutEnable=1 two cycles after its transfer cycle, if the output register is free.

Optional Feature:
Macro AQ_DJPEG_HM_BITPACK_EOI_EN.
- Defined: after the flush drain, emit 0xFF then 0xD9 via EOI_FF and EOI_D9, then DONE. No 0x00 stuffing after this 0xFF.
- Undefined: the EOI states are absent; FLUSH goes directly to DONE and the block emits no marker bytes.

Test Plan:
1. After reset, sends code 0b101 (w=3) then 0b11111 (w=5), DataOutRead=1 -> single byte 0xBF; DataOutEnable then 0, BitCount 0.
2. Sends code 0xFF (w=8), then 0x12 (w=8) -> bytes 0xFF, 0x00, 0x12 in order.
3. Sends 0b0 (w=1), then FlushIn -> byte 0x7F, FlushDone pulse one cycle after the byte is read. Without EOI, no further bytes. With EOI_EN, bytes 0x7F, 0xFF, 0xD9, no stuffing.
4. Sends code 0x7FF_FFFF (w=27) twice with DataOutRead=0 -> DataInReady drops once BitCount > 37. DataOut holds 0xFF stable. Releasing DataOutRead yields the FF/00-stuffed sequence with all 54 bits intact.
5. Sends 0b1111111 (w=7) then flush -> padded byte 0xFF followed by 0x00 stuffing, then FlushDone.
6. Asserts rst asynchronously mid-STUFF with DataOutEnable=1 -> all outputs 0 immediately. The next code 0xA5 (w=8) yields 0xA5 with no stale 0x00.

Source files
------------

// File: rtl/aq_djpeg_hm_bitpack_if.sv
// Code-word input, flush control and byte output bundle of the JPEG entropy-segment bit packer.
interface aq_djpeg_hm_bitpack_if #(
    parameter int MAX_WIDTH = 27
);
    logic                 ProcessInit;
    logic                 DataInEnable;
    logic                 DataInReady;
    logic [MAX_WIDTH-1:0] CodeIn;
    logic [4:0]           CodeWidth;
    logic                 FlushIn;
    logic                 FlushDone;
    logic                 DataOutEnable;
    logic                 DataOutRead;
    logic [7:0]           DataOut;

    modport master (
        output ProcessInit, DataInEnable, CodeIn, CodeWidth, FlushIn, DataOutRead,
        input  DataInReady, FlushDone, DataOutEnable, DataOut
    );

    modport slave (
        input  ProcessInit, DataInEnable, CodeIn, CodeWidth, FlushIn, DataOutRead,
        output DataInReady, FlushDone, DataOutEnable, DataOut
    );
endinterface

// File: rtl/aq_djpeg_hm_bitpack.sv
// Packs MSB-first code words into bytes with 0xFF/0x00 stuffing and 1-padding on flush.
// Optional EOI marker (0xFF 0xD9) after flush when AQ_DJPEG_HM_BITPACK_EOI_EN is defined.
module aq_djpeg_hm_bitpack #(
    parameter int MAX_WIDTH = 27,
    parameter int BUF_WIDTH = 64
) (
    input logic                  clk,
    input logic                  rst,
    aq_djpeg_hm_bitpack_if.slave bus
);
    localparam int CW = $clog2(BUF_WIDTH + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(BUF_WIDTH - MAX_WIDTH);

    typedef enum logic [2:0] {
        RUN,
        STUFF,
        FLUSH,
`ifdef AQ_DJPEG_HM_BITPACK_EOI_EN
        EOI_FF,
        EOI_D9,
`endif
        DONE
    } state_t;

    state_t               state, state_n;
    logic                 ret_flush, ret_n;
    logic [BUF_WIDTH-1:0] acc, acc_n, base, aligned;
    logic [CW-1:0]        cnt, cnt_n, bcnt, w, sh;
    logic [MAX_WIDTH-1:0] code_m;
    logic                 out_vld, out_stuf, ready, ready_n;
    logic [7:0]           out_dat, ld_dat;
    logic                 ld, ld_stuf, pop, clr;
    logic                 accept, rd, out_free, ff_rd;

    assign accept   = bus.DataInEnable && ready;
    assign rd       = bus.DataOutRead && out_vld;
    assign out_free = !out_vld || bus.DataOutRead;
    // Only bytes drawn from the accumulator get stuffed; marker bytes never do.
    assign ff_rd    = rd && out_stuf && (out_dat == 8'hFF);

    always_comb begin
        w       = (bus.CodeWidth > 5'(MAX_WIDTH)) ? CW'(MAX_WIDTH) : CW'(bus.CodeWidth);
        code_m  = bus.CodeIn & ~({MAX_WIDTH{1'b1}} << w);
        sh      = CW'(BUF_WIDTH) - w;
        aligned = BUF_WIDTH'(code_m) << sh;
    end

    always_comb begin
        state_n = state;
        ret_n   = ret_flush;
        ld      = 1'b0;
        ld_dat  = 8'h00;
        ld_stuf = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        case (state)
            RUN: begin
                if (ff_rd) begin
                    state_n = STUFF;
                    ret_n   = bus.FlushIn;
                end else begin
                    if (cnt >= CW'(8) && out_free) begin
                        ld = 1'b1; ld_dat = acc[BUF_WIDTH-1 -: 8]; ld_stuf = 1'b1; pop = 1'b1;
                    end
                    if (bus.FlushIn) state_n = FLUSH;
                end
            end
            STUFF: begin
                if (out_free) begin
                    ld      = 1'b1;
                    state_n = ret_flush ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (ff_rd) begin
                    state_n = STUFF;
                    ret_n   = 1'b1;
                end else if (out_free) begin
                    if (cnt >= CW'(8)) begin
                        ld = 1'b1; ld_dat = acc[BUF_WIDTH-1 -: 8]; ld_stuf = 1'b1; pop = 1'b1;
                    end else if (cnt != '0) begin
                        // Partial last byte: the bits below the valid ones are zero, fill with 1s.
                        ld = 1'b1; ld_stuf = 1'b1; clr = 1'b1;
                        ld_dat = acc[BUF_WIDTH-1 -: 8] | (8'hFF >> cnt[2:0]);
                    end else begin
`ifdef AQ_DJPEG_HM_BITPACK_EOI_EN
                        state_n = EOI_FF;
`else
                        state_n = DONE;
`endif
                    end
                end
            end
`ifdef AQ_DJPEG_HM_BITPACK_EOI_EN
            EOI_FF: begin
                if (out_free) begin
                    ld = 1'b1; ld_dat = 8'hFF; state_n = EOI_D9;
                end
            end
            EOI_D9: begin
                if (out_vld && !out_stuf && out_dat == 8'hD9) begin
                    if (rd) state_n = DONE;
                end else if (out_free) begin
                    ld = 1'b1; ld_dat = 8'hD9;
                end
            end
`endif
            DONE:    state_n = RUN;
            default: state_n = RUN;
        endcase

        base    = pop ? (acc << 8) : (clr ? '0 : acc);
        bcnt    = pop ? (cnt - CW'(8)) : (clr ? '0 : cnt);
        acc_n   = base | (accept ? (aligned >> bcnt) : '0);
        cnt_n   = bcnt + (accept ? w : '0);
        // Registered ready lags a cycle; the threshold leaves room for one more full word.
        ready_n = ((state_n == RUN) || (state_n == STUFF && !ret_n)) && (cnt_n <= READY_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN; ret_flush <= 1'b0; acc <= '0; cnt <= '0; ready <= 1'b0;
            out_vld <= 1'b0; out_dat <= 8'h00; out_stuf <= 1'b0;
        end else if (bus.ProcessInit) begin
            state <= RUN; ret_flush <= 1'b0; acc <= '0; cnt <= '0; ready <= 1'b0;
            out_vld <= 1'b0; out_dat <= 8'h00; out_stuf <= 1'b0;
        end else begin
            state     <= state_n;
            ret_flush <= ret_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ready     <= ready_n;
            if (ld) begin
                out_vld  <= 1'b1;
                out_dat  <= ld_dat;
                out_stuf <= ld_stuf;
            end else if (rd) begin
                out_vld  <= 1'b0;
            end
        end
    end

    assign bus.DataInReady   = ready;
    assign bus.DataOutEnable = out_vld;
    assign bus.DataOut       = out_dat;
    assign bus.FlushDone     = (state == DONE);
endmodule
